// File: rtl/fuzzy_pkg.sv
// Shared types, constants and the rule-index helper for the fuzzy-inference sequencer.
package fuzzy_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EST,
        S_FUZZ,
        S_RULE,
        S_DIV,
        S_DONE
    } seq_state_e;

    localparam logic [1:0] TERM_NEG  = 2'd0;
    localparam logic [1:0] TERM_ZERO = 2'd1;
    localparam logic [1:0] TERM_POS  = 2'd2;

    localparam int N_RULES_4 = 4;
    localparam int N_RULES_9 = 9;

    // Maps rule counter k to {T-term, dT-term}; the 4-rule set uses only the corner terms.
    function automatic logic [3:0] rule_idx(input logic [3:0] k, input logic mode9);
        logic [3:0] q;
        logic [3:0] r;
        logic [1:0] i;
        logic [1:0] j;
        q = k / 4'd3;
        r = k % 4'd3;
        if (mode9) begin
            i = q[1:0];
            j = r[1:0];
        end else begin
            i = k[1] ? TERM_POS : TERM_NEG;
            j = k[0] ? TERM_POS : TERM_NEG;
        end
        return {i, j};
    endfunction

endpackage

// File: rtl/fuzzy_seq_if.sv
// Control/status bundle between the sequencer and the MMIO block / fuzzy datapath.
interface fuzzy_seq_if;
    logic       start_pulse;
    logic       init_pulse;
    logic       reg_mode;
    logic       dt_mode;
    logic       div_done;
    logic       est_upd;
    logic       est_clr;
    logic       fuzz_en;
    logic       acc_clr;
    logic       rule_en;
    logic [1:0] rule_i;
    logic [1:0] rule_j;
    logic       div_start;
    logic       g_load;
    logic       busy;
    logic       valid;
    logic       ovr;
    logic       err;

    modport master (
        input  start_pulse, init_pulse, reg_mode, dt_mode, div_done,
        output est_upd, est_clr, fuzz_en, acc_clr, rule_en, rule_i, rule_j,
               div_start, g_load, busy, valid, ovr, err
    );

    modport slave (
        output start_pulse, init_pulse, reg_mode, dt_mode, div_done,
        input  est_upd, est_clr, fuzz_en, acc_clr, rule_en, rule_i, rule_j,
               div_start, g_load, busy, valid, ovr, err
    );
endinterface

// File: rtl/fuzzy_seq.sv
// Pass sequencer: EST -> FUZZ -> RULE -> DIV -> DONE, with init abort and sticky overrun.
// Optional divider watchdog enabled by defining FUZZY_SEQ_DIV_TIMEOUT_EN.
module fuzzy_seq
    import fuzzy_pkg::*;
#(
    parameter int FUZZ_LAT = 2,
    parameter int DIV_TO   = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    fuzzy_seq_if.master bus
);

    localparam logic [3:0] FUZZ_LAST = 4'(FUZZ_LAT - 1);

    seq_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       mode9_q, mode9_d;
    logic       busy_q, busy_d;
    logic       valid_q, valid_d;
    logic       ovr_q, ovr_d;
    logic       err_q, err_d;
    logic       acc_clr_q, acc_clr_d;
    logic       est_clr_q, est_clr_d;
    logic [3:0] rule_last;
    logic       div_timeout;

    assign rule_last = mode9_q ? 4'(N_RULES_9 - 1) : 4'(N_RULES_4 - 1);

`ifdef FUZZY_SEQ_DIV_TIMEOUT_EN
    localparam int TO_W = $clog2(DIV_TO + 1);
    logic [TO_W-1:0] to_cnt_q;

    // Watchdog counts DIV cycles without div_done; restarts whenever DIV is (re)entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            to_cnt_q <= '0;
        else if (state_q != S_DIV || bus.init_pulse)
            to_cnt_q <= '0;
        else if (!bus.div_done)
            to_cnt_q <= to_cnt_q + TO_W'(1);
    end

    assign div_timeout = (state_q == S_DIV) && !bus.div_done &&
                         (to_cnt_q == TO_W'(DIV_TO - 1));
`else
    assign div_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            mode9_q   <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            ovr_q     <= 1'b0;
            err_q     <= 1'b0;
            acc_clr_q <= 1'b0;
            est_clr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mode9_q   <= mode9_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            ovr_q     <= ovr_d;
            err_q     <= err_d;
            acc_clr_q <= acc_clr_d;
            est_clr_q <= est_clr_d;
        end
    end

    // Init overrides everything; otherwise cnt is reused as FUZZ timer, rule k, and DIV first-cycle flag.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mode9_d   = mode9_q;
        busy_d    = busy_q;
        valid_d   = valid_q;
        ovr_d     = ovr_q;
        err_d     = err_q;
        acc_clr_d = 1'b0;
        est_clr_d = 1'b0;

        if (bus.init_pulse) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            busy_d    = 1'b0;
            valid_d   = 1'b0;
            ovr_d     = 1'b0;
            err_d     = 1'b0;
            acc_clr_d = 1'b1;
            est_clr_d = 1'b1;
        end else begin
            if (bus.start_pulse && busy_q)
                ovr_d = 1'b1;

            case (state_q)
                S_IDLE: begin
                    if (bus.start_pulse) begin
                        state_d   = bus.dt_mode ? S_EST : S_FUZZ;
                        cnt_d     = '0;
                        mode9_d   = bus.reg_mode;
                        acc_clr_d = 1'b1;
                        busy_d    = 1'b1;
                        valid_d   = 1'b0;
                    end
                end
                S_EST: begin
                    state_d = S_FUZZ;
                    cnt_d   = '0;
                end
                S_FUZZ: begin
                    if (cnt_q == FUZZ_LAST) begin
                        state_d = S_RULE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                S_RULE: begin
                    if (cnt_q == rule_last) begin
                        state_d = S_DIV;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                S_DIV: begin
                    cnt_d = 4'd1;
                    if (bus.div_done) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        valid_d = 1'b1;
                    end else if (div_timeout) begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        valid_d = 1'b0;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign bus.est_upd   = (state_q == S_EST);
    assign bus.fuzz_en   = (state_q == S_FUZZ);
    assign bus.rule_en   = (state_q == S_RULE);
    assign {bus.rule_i, bus.rule_j} = (state_q == S_RULE) ? rule_idx(cnt_q, mode9_q) : 4'd0;
    assign bus.div_start = (state_q == S_DIV) && (cnt_q == 4'd0);
    assign bus.g_load    = (state_q == S_DONE);
    assign bus.busy      = busy_q;
    assign bus.valid     = valid_q;
    assign bus.ovr       = ovr_q;
    assign bus.err       = err_q;
    assign bus.acc_clr   = acc_clr_q;
    assign bus.est_clr   = est_clr_q;

endmodule

// File: tb/tb_fuzzy_seq.sv
// Directed self-checking bench for fuzzy_seq; define FUZZY_SEQ_DIV_TIMEOUT_EN to expect the watchdog.
module tb_fuzzy_seq;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    int   pi4[4] = '{0, 0, 2, 2};
    int   pj4[4] = '{0, 2, 0, 2};

`ifdef FUZZY_SEQ_DIV_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    fuzzy_seq_if bus_if ();

    fuzzy_seq #(.FUZZ_LAT(2), .DIV_TO(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] pack(input logic eu, input logic ec, input logic fe,
                                         input logic ac, input logic re,
                                         input logic [1:0] ri, input logic [1:0] rj,
                                         input logic ds, input logic gl, input logic bs,
                                         input logic vl, input logic ov, input logic er);
        return {eu, ec, fe, ac, re, ri, rj, ds, gl, bs, vl, ov, er};
    endfunction

    function automatic logic [14:0] outs();
        return pack(bus_if.est_upd, bus_if.est_clr, bus_if.fuzz_en, bus_if.acc_clr,
                    bus_if.rule_en, bus_if.rule_i, bus_if.rule_j, bus_if.div_start,
                    bus_if.g_load, bus_if.busy, bus_if.valid, bus_if.ovr, bus_if.err);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic i, input logic r,
                                 input logic d, input logic dd);
        bus_if.start_pulse = s;
        bus_if.init_pulse  = i;
        bus_if.reg_mode    = r;
        bus_if.dt_mode     = d;
        bus_if.div_done    = dd;
    endtask

    task automatic checkOutput(input string tag, input logic [14:0] obs, input logic [14:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // dt_mode=0, reg_mode=0, D=0 pass; modes flipped mid-pass must have no effect.
    task automatic runShortPass(input logic second_start, input string pfx);
        int idx;
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput({pfx, "_c0"}, outs(), pack(0,0,0,0,0,2'd0,2'd0,0,0,0,1,0,0));
        for (int c = 1; c <= 9; c++) begin
            tick();
            applyStimulus(second_start && c == 4, 0, 1, 1, c == 7);
            idx = (c >= 3 && c <= 6) ? c - 3 : 0;
            checkOutput($sformatf("%s_c%0d", pfx, c), outs(),
                        pack(0, 0, c >= 1 && c <= 2, c == 1, c >= 3 && c <= 6,
                             (c >= 3 && c <= 6) ? 2'(pi4[idx]) : 2'd0,
                             (c >= 3 && c <= 6) ? 2'(pj4[idx]) : 2'd0,
                             c == 7, c == 8, c >= 1 && c <= 7, c >= 8,
                             second_start && c >= 5, 0));
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        applyStimulus(0, 0, 0, 0, 0);

        tick();
        tick();
        checkOutput("reset_state", outs(), 15'd0);
        rst_n = 1'b1;
        tick();
        checkOutput("idle_after_reset", outs(), 15'd0);

        // Full 9-rule pass with estimator, divider latency 3.
        applyStimulus(1, 0, 1, 1, 0);
        checkOutput("p9_c0", outs(), 15'd0);
        for (int c = 1; c <= 18; c++) begin
            tick();
            applyStimulus(0, 0, 0, 0, c == 16);
            checkOutput($sformatf("p9_c%0d", c), outs(),
                        pack(c == 1, 0, c >= 2 && c <= 3, c == 1, c >= 4 && c <= 12,
                             (c >= 4 && c <= 12) ? 2'((c - 4) / 3) : 2'd0,
                             (c >= 4 && c <= 12) ? 2'((c - 4) % 3) : 2'd0,
                             c == 13, c == 17, c >= 1 && c <= 16, c >= 17, 0, 0));
        end

        runShortPass(1'b0, "p4");
        runShortPass(1'b1, "ovr");

        // Init clears sticky overrun and valid.
        applyStimulus(0, 1, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("ovr_init_c10", outs(), pack(0,1,0,1,0,2'd0,2'd0,0,0,0,0,0,0));
        tick();
        checkOutput("ovr_init_c11", outs(), 15'd0);

        // Abort during DIV with a late div_done that must be ignored.
        applyStimulus(1, 0, 0, 1, 0);
        checkOutput("abort_c0", outs(), 15'd0);
        for (int c = 1; c <= 12; c++) begin
            int idx;
            tick();
            applyStimulus(0, c == 9, 0, 0, c == 10);
            idx = (c >= 4 && c <= 7) ? c - 4 : 0;
            checkOutput($sformatf("abort_c%0d", c), outs(),
                        pack(c == 1, c == 10, c >= 2 && c <= 3, c == 1 || c == 10,
                             c >= 4 && c <= 7,
                             (c >= 4 && c <= 7) ? 2'(pi4[idx]) : 2'd0,
                             (c >= 4 && c <= 7) ? 2'(pj4[idx]) : 2'd0,
                             c == 8, 0, c >= 1 && c <= 9, 0, 0, 0));
        end

        // Simultaneous start and init: init wins, no overrun.
        applyStimulus(1, 1, 1, 1, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("start_init_c1", outs(), pack(0,1,0,1,0,2'd0,2'd0,0,0,0,0,0,0));
        tick();
        checkOutput("start_init_c2", outs(), 15'd0);

        // Stray div_done in IDLE is ignored.
        applyStimulus(0, 0, 0, 0, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("stray_div_done", outs(), 15'd0);

        // Asynchronous reset in the middle of FUZZ.
        applyStimulus(1, 0, 1, 1, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0);
        tick();
        checkOutput("areset_pre", outs(), pack(0,0,1,0,0,2'd0,2'd0,0,0,1,0,0,0));
        #2 rst_n = 1'b0;
        #1;
        checkOutput("areset_now", outs(), 15'd0);
        tick();
        checkOutput("areset_held", outs(), 15'd0);
        rst_n = 1'b1;
        tick();
        checkOutput("areset_released", outs(), 15'd0);

        // Divider never answers: watchdog trips after 32 DIV cycles, or DIV waits until init.
        applyStimulus(1, 0, 1, 1, 0);
        checkOutput("wd_c0", outs(), 15'd0);
        for (int c = 1; c <= 47; c++) begin
            tick();
            applyStimulus(0, c == 46, 0, 0, 0);
            checkOutput($sformatf("wd_c%0d", c), outs(),
                        pack(c == 1, c == 47, c >= 2 && c <= 3, c == 1 || c == 47,
                             c >= 4 && c <= 12,
                             (c >= 4 && c <= 12) ? 2'((c - 4) / 3) : 2'd0,
                             (c >= 4 && c <= 12) ? 2'((c - 4) % 3) : 2'd0,
                             c == 13, 0,
                             TO_EN ? (c >= 1 && c <= 44) : (c >= 1 && c <= 46),
                             0, 0,
                             TO_EN && c >= 45 && c <= 46));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
